// File: rtl/canvas_port_arbiter.sv
// Canvas RAM port arbiter: shares the single port of the 32x32 one-bit canvas
// among the clear sweeper (highest priority), the stroke rasterizer draw stream
// and the glyph recognizer full-canvas read scan (lowest priority).
module canvas_port_arbiter #(
   parameter int ADDR_W         = 10,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_req,
   output logic              clear_busy,
   input  logic              draw_valid,
   input  logic [ADDR_W-1:0] draw_addr,
   input  logic              draw_data,
   output logic              draw_ready,
   input  logic              scan_start,
   output logic              scan_busy,
   output logic              scan_bit_valid,
   output logic              scan_bit,
   output logic [ADDR_W-1:0] scan_addr,
   output logic              scan_done,
   output logic              scan_abort,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_wdata,
   input  logic              mem_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, SCAN = 2'd2} state_t;

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam state_t            RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [ADDR_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              scan_pend_q, scan_pend_d;
   logic              rd_vld_q, rd_vld_d;

   logic              draw_ready_w, we_w, wdata_w, rd_issue;
   logic              abort_w, busy_base, start_acc, clr_last;

   // A clear arriving while scanning kills the scan; the read already in
   // flight is dropped rather than delivered.
   assign abort_w   = (state_q == SCAN) && clear_req;
   // Busy covers an active scan, a scan queued behind a clear, and the cycle
   // that delivers the final bit (the FSM is already back in IDLE then).
   assign busy_base = (state_q == SCAN) || scan_pend_q ||
                      (rd_vld_q && (rd_addr_q == ADDR_LAST));
   assign start_acc = scan_start && !busy_base;
   assign clr_last  = (state_q == CLEAR) && !clear_req && (clr_cnt_q == '0);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RST_STATE;
      else     state_q <= state_d;
   end

   // Next-state selection with clear > draw > scan priority
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (clear_req)      state_d = CLEAR;
                  else if (start_acc) state_d = SCAN;
         CLEAR:   if (clr_last)       state_d = (scan_pend_q || start_acc) ? SCAN : IDLE;
         SCAN:    if (clear_req)      state_d = CLEAR;
                  else if (rd_issue && (scan_cnt_q == ADDR_LAST)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Port ownership: who drives the RAM this cycle; address holds when unowned
   always_comb begin
      draw_ready_w = 1'b0;
      we_w         = 1'b0;
      wdata_w      = 1'b0;
      rd_issue     = 1'b0;
      mem_addr_d   = mem_addr_q;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               draw_ready_w = !clear_req;
               if (draw_valid && !clear_req) begin
                  we_w       = 1'b1;
                  wdata_w    = draw_data;
                  mem_addr_d = draw_addr;
               end
            end
            CLEAR: begin
               we_w       = 1'b1;
               mem_addr_d = clr_cnt_q;
            end
            SCAN: begin
               if (!clear_req) begin
                  draw_ready_w = 1'b1;
                  if (draw_valid) begin
                     we_w       = 1'b1;
                     wdata_w    = draw_data;
                     mem_addr_d = draw_addr;
                  end else begin
                     rd_issue   = 1'b1;
                     mem_addr_d = scan_cnt_q;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Counter, pending-scan and read-pipeline next values
   always_comb begin
      clr_cnt_d = clr_cnt_q;
      if (clear_req)              clr_cnt_d = ADDR_LAST;
      else if (state_q == CLEAR)  clr_cnt_d = (clr_cnt_q == '0) ? ADDR_LAST : clr_cnt_q - ADDR_ONE;

      scan_cnt_d = scan_cnt_q;
      if ((state_q != SCAN) && (state_d == SCAN)) scan_cnt_d = '0;
      else if (rd_issue) scan_cnt_d = (scan_cnt_q == ADDR_LAST) ? '0 : scan_cnt_q + ADDR_ONE;

      scan_pend_d = scan_pend_q;
      if (start_acc && ((state_q == CLEAR) || clear_req)) scan_pend_d = 1'b1;
      if (((state_q == CLEAR) && (state_d == SCAN)) || abort_w) scan_pend_d = 1'b0;

      rd_vld_d  = rd_issue;
      rd_addr_d = rd_issue ? scan_cnt_q : rd_addr_q;
   end

   // Counter, pending-scan and read-pipeline registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_cnt_q   <= ADDR_LAST;
         scan_cnt_q  <= '0;
         scan_pend_q <= 1'b0;
         rd_vld_q    <= 1'b0;
         rd_addr_q   <= '0;
         mem_addr_q  <= '0;
      end else begin
         clr_cnt_q   <= clr_cnt_d;
         scan_cnt_q  <= scan_cnt_d;
         scan_pend_q <= scan_pend_d;
         rd_vld_q    <= rd_vld_d;
         rd_addr_q   <= rd_addr_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

   assign draw_ready     = draw_ready_w;
   assign mem_we         = we_w;
   assign mem_wdata      = wdata_w;
   assign mem_addr       = mem_addr_d;
   assign clear_busy     = (state_q == CLEAR);
   assign scan_abort     = abort_w && !rst;
   assign scan_bit_valid = rd_vld_q && !abort_w;
   assign scan_bit       = scan_bit_valid && mem_rdata;
   assign scan_addr      = rd_addr_q;
   assign scan_done      = scan_bit_valid && (rd_addr_q == ADDR_LAST);
   assign scan_busy      = !rst && (busy_base || start_acc);

endmodule

// File: tb/tb_canvas_port_arbiter.sv
// Bench for canvas_port_arbiter: behavioural BRAM plus a canvas model that
// predicts cleared/drawn pixels and the ordered scan stream.
module tb_canvas_port_arbiter;
   localparam int AW = 10;
   localparam int N  = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear_req, draw_valid, draw_data, scan_start;
   logic [AW-1:0] draw_addr;
   logic          clear_busy, draw_ready, scan_busy, scan_bit_valid, scan_bit;
   logic          scan_done, scan_abort, mem_we, mem_wdata, mem_rdata;
   logic [AW-1:0] scan_addr, mem_addr;

   logic ram [N];
   bit   model [N];
   int   tests_run = 0;
   int   tests_failed = 0;

   canvas_port_arbiter #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(clear_busy),
      .draw_valid(draw_valid), .draw_addr(draw_addr), .draw_data(draw_data),
      .draw_ready(draw_ready), .scan_start(scan_start), .scan_busy(scan_busy),
      .scan_bit_valid(scan_bit_valid), .scan_bit(scan_bit), .scan_addr(scan_addr),
      .scan_done(scan_done), .scan_abort(scan_abort), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Canvas BRAM: read-first, one cycle read latency
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      clear_req  = 1'b0;
      draw_valid = 1'b0;
      draw_addr  = '0;
      draw_data  = 1'b0;
      scan_start = 1'b0;
   endtask

   // Full clear sweep: descending addresses, optional restart when the sweep
   // reaches restart_at; draw_valid is held high to show draws are refused.
   task automatic clear_sweep(input int restart_at, input bit pend_exp);
      int exp_a = N - 1;
      bit restarted = 1'b0;
      bit fin = 1'b0;
      int guard = 0;
      while (!fin && guard < 3 * N) begin
         step();
         rst = 1'b0;
         idle_inputs();
         draw_valid = 1'b1;
         draw_addr  = AW'($urandom);
         draw_data  = 1'b1;
         clear_req  = !restarted && (exp_a == restart_at);
         sample();
         guard++;
         tests_run++;
         if ({mem_we, mem_wdata, draw_ready, clear_busy} !== 4'b1001) begin
            tests_failed++;
            $display("FAIL sweep_ctrl: got we/wd/rdy/busy=%b want 1001", {mem_we, mem_wdata, draw_ready, clear_busy});
         end
         tests_run++;
         if (mem_addr !== AW'(exp_a)) begin
            tests_failed++;
            $display("FAIL sweep_addr: got %0d want %0d", mem_addr, exp_a);
         end
         tests_run++;
         if ({scan_busy, scan_bit_valid, scan_abort} !== {pend_exp, 2'b00}) begin
            tests_failed++;
            $display("FAIL sweep_scan_flags: got busy/vld/abort=%b want %b00", {scan_busy, scan_bit_valid, scan_abort}, pend_exp);
         end
         if (clear_req) begin
            restarted = 1'b1;
            exp_a = N - 1;
         end else if (exp_a == 0) begin
            fin = 1'b1;
         end else begin
            exp_a--;
         end
      end
      tests_run++;
      if (!fin) begin
         tests_failed++;
         $display("FAIL sweep_timeout: got unfinished after %0d cycles want finish", guard);
      end
      for (int i = 0; i < N; i++) model[i] = 1'b0;
   endtask

   // Start a scan from IDLE
   task automatic start_scan();
      step();
      idle_inputs();
      scan_start = 1'b1;
      sample();
      tests_run++;
      if ({scan_busy, scan_bit_valid, mem_we, draw_ready} !== 4'b1001) begin
         tests_failed++;
         $display("FAIL scan_start_cycle: got busy/vld/we/rdy=%b want 1001", {scan_busy, scan_bit_valid, mem_we, draw_ready});
      end
   endtask

   // Collect a running scan: beats must arrive 0..N-1 in order with model data;
   // random draws stall the scan by one cycle each.
   task automatic scan_collect(input int pct, input int burst_at);
      int exp_a = 0;
      int cyc = 0;
      int stalls = 0;
      int burst = 0;
      bit done = 1'b0;
      while (!done && cyc < 4 * N) begin
         step();
         idle_inputs();
         if (burst > 0) begin
            draw_valid = 1'b1;
            burst--;
         end else begin
            draw_valid = ($urandom_range(0, 99) < pct);
         end
         draw_addr  = AW'($urandom);
         draw_data  = 1'($urandom);
         scan_start = ($urandom_range(0, 7) == 0);
         sample();
         cyc++;
         tests_run++;
         if ({draw_ready, mem_we} !== {1'b1, draw_valid}) begin
            tests_failed++;
            $display("FAIL scan_port: got rdy/we=%b want 1%b", {draw_ready, mem_we}, draw_valid);
         end
         if (draw_valid) begin
            tests_run++;
            if ({mem_addr, mem_wdata} !== {draw_addr, draw_data}) begin
               tests_failed++;
               $display("FAIL scan_draw_write: got addr %0d data %b want addr %0d data %b", mem_addr, mem_wdata, draw_addr, draw_data);
            end
         end
         tests_run++;
         if ({scan_busy, scan_abort} !== 2'b10) begin
            tests_failed++;
            $display("FAIL scan_busy_flags: got busy/abort=%b want 10", {scan_busy, scan_abort});
         end
         if (scan_bit_valid) begin
            tests_run++;
            if (scan_addr !== AW'(exp_a)) begin
               tests_failed++;
               $display("FAIL scan_order: got addr %0d want %0d", scan_addr, exp_a);
            end
            tests_run++;
            if ({scan_bit, scan_done} !== {model[exp_a], exp_a == N - 1}) begin
               tests_failed++;
               $display("FAIL scan_bit_done: got bit/done=%b at %0d want %b%b", {scan_bit, scan_done}, exp_a, model[exp_a], exp_a == N - 1);
            end
            if (exp_a == burst_at) burst = 3;
            done = (exp_a == N - 1);
            exp_a++;
         end else begin
            tests_run++;
            if (scan_done !== 1'b0) begin
               tests_failed++;
               $display("FAIL scan_done_spurious: got 1 want 0");
            end
         end
         if (draw_valid && !done) stalls++;
         if (draw_valid) model[draw_addr] = draw_data;
      end
      tests_run++;
      if (!done) begin
         tests_failed++;
         $display("FAIL scan_timeout: got %0d beats want %0d", exp_a, N);
      end
      tests_run++;
      if (cyc !== N + 1 + stalls) begin
         tests_failed++;
         $display("FAIL scan_cycles: got %0d want %0d", cyc, N + 1 + stalls);
      end
      step();
      idle_inputs();
      sample();
      tests_run++;
      if ({scan_busy, scan_bit_valid, scan_done} !== 3'b000) begin
         tests_failed++;
         $display("FAIL scan_after_done: got busy/vld/done=%b want 000", {scan_busy, scan_bit_valid, scan_done});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      sample();
      tests_run++;
      if ({clear_busy, mem_we, mem_wdata, draw_ready, scan_busy, scan_bit_valid, scan_done, scan_abort, scan_bit} !== 9'b1_0000_0000) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b want 100000000", {clear_busy, mem_we, mem_wdata, draw_ready, scan_busy, scan_bit_valid, scan_done, scan_abort, scan_bit});
      end
      tests_run++;
      if ({mem_addr, scan_addr} !== '0) begin
         tests_failed++;
         $display("FAIL reset_addr: got mem %0d scan %0d want 0 0", mem_addr, scan_addr);
      end
   endtask

   task automatic test_clear_on_reset();
      clear_sweep(-1, 1'b0);
      step();
      idle_inputs();
      draw_valid = 1'b1;
      draw_addr  = 10'h3c5;
      draw_data  = 1'b1;
      sample();
      tests_run++;
      if ({draw_ready, mem_we, mem_wdata, clear_busy, mem_addr} !== {4'b1110, 10'h3c5}) begin
         tests_failed++;
         $display("FAIL first_draw: got rdy/we/wd/busy=%b addr %0h want 1110 addr 3c5", {draw_ready, mem_we, mem_wdata, clear_busy}, mem_addr);
      end
      model[10'h3c5] = 1'b1;
   endtask

   task automatic test_draw_idle();
      logic [AW-1:0] last_a;
      step();
      idle_inputs();
      draw_valid = 1'b1;
      draw_addr  = 10'h021;
      draw_data  = 1'b1;
      sample();
      tests_run++;
      if ({draw_ready, mem_we, mem_wdata, mem_addr} !== {3'b111, 10'h021}) begin
         tests_failed++;
         $display("FAIL idle_draw_021: got rdy/we/wd=%b addr %0h want 111 addr 021", {draw_ready, mem_we, mem_wdata}, mem_addr);
      end
      model[10'h021] = 1'b1;
      last_a = 10'h021;
      for (int i = 0; i < 40; i++) begin
         step();
         idle_inputs();
         draw_valid = 1'($urandom);
         draw_addr  = AW'($urandom);
         draw_data  = 1'($urandom);
         sample();
         if (draw_valid) last_a = draw_addr;
         tests_run++;
         if ({draw_ready, mem_we, mem_addr} !== {1'b1, draw_valid, last_a}) begin
            tests_failed++;
            $display("FAIL idle_draw_rand: got rdy/we=%b addr %0d want 1%b addr %0d", {draw_ready, mem_we}, mem_addr, draw_valid, last_a);
         end
         if (draw_valid) begin
            tests_run++;
            if (mem_wdata !== draw_data) begin
               tests_failed++;
               $display("FAIL idle_draw_data: got %b want %b", mem_wdata, draw_data);
            end
            model[draw_addr] = draw_data;
         end
      end
   endtask

   task automatic test_scan_full();
      step();
      idle_inputs();
      clear_req = 1'b1;
      sample();
      tests_run++;
      if ({draw_ready, mem_we, clear_busy} !== 3'b000) begin
         tests_failed++;
         $display("FAIL clear_entry: got rdy/we/busy=%b want 000", {draw_ready, mem_we, clear_busy});
      end
      clear_sweep(-1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         step();
         idle_inputs();
         draw_valid = 1'b1;
         draw_addr  = (k == 0) ? AW'(5) : AW'(N - 1);
         draw_data  = 1'b1;
         sample();
         tests_run++;
         if ({mem_we, mem_addr} !== {1'b1, draw_addr}) begin
            tests_failed++;
            $display("FAIL preload: got we %b addr %0d want 1 addr %0d", mem_we, mem_addr, draw_addr);
         end
         model[draw_addr] = 1'b1;
      end
      start_scan();
      scan_collect(0, -1);
   endtask

   task automatic test_scan_stall();
      start_scan();
      scan_collect(25, 100);
   endtask

   task automatic test_clear_abort();
      int exp_a = 0;
      int guard = 0;
      bit found = 1'b0;
      start_scan();
      while (!found && guard < 2 * N) begin
         step();
         idle_inputs();
         sample();
         guard++;
         if (scan_bit_valid) begin
            tests_run++;
            if (scan_addr !== AW'(exp_a)) begin
               tests_failed++;
               $display("FAIL abort_prefix: got addr %0d want %0d", scan_addr, exp_a);
            end
            if (exp_a == 499) found = 1'b1;
            exp_a++;
         end
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL abort_reach: got %0d beats want 500", exp_a);
      end
      step();
      idle_inputs();
      clear_req  = 1'b1;
      draw_valid = 1'b1;
      sample();
      tests_run++;
      if ({scan_abort, scan_bit_valid, draw_ready, mem_we, clear_busy} !== 5'b10000) begin
         tests_failed++;
         $display("FAIL abort_cycle: got abort/vld/rdy/we/busy=%b want 10000", {scan_abort, scan_bit_valid, draw_ready, mem_we, clear_busy});
      end
      clear_sweep(300, 1'b0);
   endtask

   task automatic test_start_with_clear();
      step();
      idle_inputs();
      scan_start = 1'b1;
      clear_req  = 1'b1;
      draw_valid = 1'b1;
      sample();
      tests_run++;
      if ({scan_busy, draw_ready, mem_we, clear_busy} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL start_clear_cycle: got busy/rdy/we/cbusy=%b want 1000", {scan_busy, draw_ready, mem_we, clear_busy});
      end
      clear_sweep(-1, 1'b1);
      scan_collect(20, -1);
   endtask

   task automatic test_reset_mid();
      start_scan();
      repeat (50) begin
         step();
         idle_inputs();
      end
      step();
      rst        = 1'b1;
      clear_req  = 1'b1;
      draw_valid = 1'b1;
      scan_start = 1'b1;
      sample();
      tests_run++;
      if ({scan_abort, scan_bit_valid, scan_busy, mem_we, draw_ready, scan_done, clear_busy} !== 7'b0000001) begin
         tests_failed++;
         $display("FAIL reset_mid: got %b want 0000001", {scan_abort, scan_bit_valid, scan_busy, mem_we, draw_ready, scan_done, clear_busy});
      end
      clear_sweep(-1, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         ram[i]   = 1'($urandom);
         model[i] = 1'b0;
      end
      idle_inputs();
      test_reset();
      test_clear_on_reset();
      test_draw_idle();
      test_scan_full();
      test_scan_stall();
      test_clear_abort();
      test_start_with_clear();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
